// File: rtl/console_pkg.sv
// Shared types and constants for the text console: FSM states, cell geometry, control codes.
package console_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SCROLL = 2'd2
    } state_t;

    localparam int CELL_W = 8;
    localparam int CELL_H = 16;

    localparam logic [6:0] CH_BS = 7'h08;
    localparam logic [6:0] CH_LF = 7'h0A;
    localparam logic [6:0] CH_FF = 7'h0C;
    localparam logic [6:0] CH_SP = 7'h20;

    function automatic logic is_printable(input logic [6:0] c);
        return (c >= CH_SP) && (c <= 7'h7E);
    endfunction

endpackage

// File: rtl/ascii_rom.sv
// 8x16 glyph ROM, 1-cycle registered read: 'A' in full, a box outline for other printable codes,
// blank for space and control codes.
module ascii_rom (
    input  logic       clk,
    input  logic [6:0] code,
    input  logic [3:0] row,
    output logic [7:0] data
);

    function automatic logic [7:0] lookup(input logic [6:0] c, input logic [3:0] r);
        logic [7:0] g;
        g = 8'h00;
        if (c == 7'h41) begin
            case (r)
                4'd2:    g = 8'h10;
                4'd3:    g = 8'h38;
                4'd4:    g = 8'h6C;
                4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: g = 8'hC6;
                4'd7:    g = 8'hFE;
                default: g = 8'h00;
            endcase
        end else if (c > 7'h20 && c < 7'h7F) begin
            if (r == 4'd2 || r == 4'd13)
                g = 8'h7E;
            else if (r > 4'd2 && r < 4'd13)
                g = 8'h42;
        end
        return g;
    endfunction

    always_ff @(posedge clk) begin
        data <= lookup(code, row);
    end

endmodule

// File: rtl/console_ram.sv
// Dual-port text buffer: one write port, one registered read port (1-cycle latency).
// A read of the address being written returns the previous contents.
module console_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [6:0]    wdat,
    input  logic [AW-1:0] raddr,
    output logic [6:0]    rdat
);

    logic [6:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdat;
    end

    always_ff @(posedge clk) begin
        rdat <= mem[raddr];
    end

endmodule

// File: rtl/text_console.sv
// Character console overlay: rgb lags x/y/video_on by 2 cycles; optional blinking cursor via CONSOLE_CURSOR_EN.
// Writes are accepted only in IDLE; wr_ready drops for COLS cycles on scroll and COLS*ROWS on clear.
module text_console
    import console_pkg::*;
#(
    parameter int          COLS = 32,
    parameter int          ROWS = 4,
    parameter int          X0   = 192,
    parameter int          Y0   = 208,
    parameter logic [11:0] FG   = 12'h00F,
    parameter logic [11:0] BG   = 12'hFFF
`ifdef CONSOLE_CURSOR_EN
    , parameter int        BLINK_CYCLES = 25_000_000
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        wr_valid,
    input  logic [6:0]  wr_char,
    output logic        wr_ready,
    output logic [11:0] rgb,
    output logic [6:0]  cur_col,
    output logic [4:0]  cur_row
);

    localparam int N  = COLS * ROWS;
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    state_t        state;
    logic [AW-1:0] cnt;
    logic [4:0]    top;
    logic          we;
    logic [AW-1:0] waddr, raddr;
    logic [6:0]    wdat, rdat;

    // Logical row to physical row through the circular scroll offset.
    function automatic logic [4:0] phys_row(input logic [4:0] r, input logic [4:0] t);
        logic [5:0] s;
        s = {1'b0, r} + {1'b0, t};
        if (s >= 6'(ROWS))
            s = s - 6'(ROWS);
        return s[4:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [4:0] prow, input logic [6:0] col);
        return AW'(int'(prow) * COLS + int'(col));
    endfunction

    // ---------------- display path ----------------
    logic [9:0]  dx;
    logic [8:0]  dy;
    logic        in_win0;
    logic        von1, von2, win1, win2;
    logic [2:0]  bit1, bit2;
    logic [3:0]  row1;
    logic [7:0]  glyph;
    logic        pix;

    assign dx      = x - 10'(X0);
    assign dy      = 9'(y - 10'(Y0));
    assign in_win0 = ({1'b0, x} >= 11'(X0)) && ({1'b0, x} < 11'(X0 + CELL_W * COLS)) &&
                     ({1'b0, y} >= 11'(Y0)) && ({1'b0, y} < 11'(Y0 + CELL_H * ROWS));
    assign raddr   = cell_addr(phys_row(dy[8:4], top), dx[9:3]);

    always_ff @(posedge clk) begin
        if (reset) begin
            von1 <= 1'b0;
            von2 <= 1'b0;
            win1 <= 1'b0;
            win2 <= 1'b0;
            bit1 <= '0;
            bit2 <= '0;
            row1 <= '0;
        end else begin
            von1 <= video_on;
            von2 <= von1;
            win1 <= in_win0;
            win2 <= win1;
            bit1 <= dx[2:0];
            bit2 <= bit1;
            row1 <= dy[3:0];
        end
    end

    console_ram #(.DEPTH(N), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdat  (wdat),
        .raddr (raddr),
        .rdat  (rdat)
    );

    ascii_rom u_rom (
        .clk  (clk),
        .code (rdat),
        .row  (row1),
        .data (glyph)
    );

`ifdef CONSOLE_CURSOR_EN
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    logic [BW-1:0] blink_cnt;
    logic          phase, cur1, cur2;
    logic [3:0]    row2;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
            cur1      <= 1'b0;
            cur2      <= 1'b0;
            row2      <= '0;
        end else begin
            if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            cur1 <= (dx[9:3] == cur_col) && (dy[8:4] == cur_row);
            cur2 <= cur1;
            row2 <= row1;
        end
    end

    assign pix = glyph[3'd7 - bit2] | (phase && cur2 && (row2 >= 4'd14));
`else
    assign pix = glyph[3'd7 - bit2];
`endif

    assign rgb = !von2 ? 12'h000 : ((win2 && pix) ? FG : BG);

    // ---------------- write port ----------------
    always_comb begin
        we    = 1'b0;
        waddr = cnt;
        wdat  = CH_SP;
        case (state)
            CLEAR:  we = 1'b1;
            SCROLL: begin
                we    = 1'b1;
                waddr = cell_addr(phys_row(5'(ROWS - 1), top), 7'(cnt));
            end
            default: begin
                if (wr_valid && wr_ready) begin
                    if (is_printable(wr_char)) begin
                        we    = 1'b1;
                        waddr = cell_addr(phys_row(cur_row, top), cur_col);
                        wdat  = wr_char;
                    end else if (wr_char == CH_BS && cur_col != 7'd0) begin
                        we    = 1'b1;
                        waddr = cell_addr(phys_row(cur_row, top), cur_col - 7'd1);
                    end
                end
            end
        endcase
        // The write landing on a reset edge is dropped.
        if (reset)
            we = 1'b0;
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            cnt      <= '0;
            top      <= '0;
            cur_col  <= '0;
            cur_row  <= '0;
            wr_ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (cnt == AW'(N - 1)) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        top      <= '0;
                        cur_col  <= '0;
                        cur_row  <= '0;
                        wr_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SCROLL: begin
                    if (cnt == AW'(COLS - 1)) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        wr_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (wr_valid && wr_ready) begin
                        if (is_printable(wr_char) || wr_char == CH_LF) begin
                            if (wr_char == CH_LF || cur_col == 7'(COLS - 1)) begin
                                cur_col <= '0;
                                if (cur_row == 5'(ROWS - 1)) begin
                                    top      <= (top == 5'(ROWS - 1)) ? 5'd0 : top + 5'd1;
                                    state    <= SCROLL;
                                    cnt      <= '0;
                                    wr_ready <= 1'b0;
                                end else begin
                                    cur_row <= cur_row + 5'd1;
                                end
                            end else begin
                                cur_col <= cur_col + 7'd1;
                            end
                        end else if (wr_char == CH_BS) begin
                            if (cur_col != 7'd0)
                                cur_col <= cur_col - 7'd1;
                        end else if (wr_char == CH_FF) begin
                            state    <= CLEAR;
                            cnt      <= '0;
                            wr_ready <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/text_console.md
TEXT_CONSOLE -- requirements
Module: text_console

Interface
REQ-001 Parameter COLS, default 32: text columns; 1..128.
REQ-002 Parameter ROWS, default 4: text rows; 1..32.
REQ-003 Parameter X0, default 192; Y0, default 208: pixel origin of the text window; cells are 8x16 pixels.
REQ-004 Parameters FG, default 12'h00F; BG, default 12'hFFF: glyph and background colour.
REQ-005 clk  in  1  pixel clock; the single clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 video_on  in  1  visible-area flag from the sync generator.
REQ-008 x, y  in  10 each  current pixel coordinate.
REQ-009 wr_valid  in  1  character-write request.
REQ-010 wr_char  in  7  ASCII code to write.
REQ-011 wr_ready  out  1  accept qualifier; a transfer occurs when wr_valid and wr_ready are both high on a rising clk edge.
REQ-012 rgb  out  12  pixel colour, aligned 2 cycles after x/y/video_on.
REQ-013 cur_col  out  7; cur_row  out  5  current cursor position (logical row).

Function
REQ-014 Text buffer SHALL hold COLS*ROWS 7-bit codes in a synchronous-read RAM; the display path SHALL have a fixed latency of 2 cycles: RAM read, then glyph-ROM read.
REQ-015 Inside the window (X0<=x<X0+8*COLS, Y0<=y<Y0+16*ROWS), rgb SHALL be FG where the glyph bit is 1, else BG; outside the window rgb SHALL be BG; when the delayed video_on is 0, rgb SHALL be 12'h000.
REQ-016 Glyph bit SHALL be ROM bit 7-(x-X0)[2:0], and the ROM row SHALL be (y-Y0)[3:0].
REQ-017 Displayed logical row r SHALL read physical row (r+top) mod ROWS, where top is the circular scroll offset.
REQ-018 FSM states SHALL be IDLE, CLEAR and SCROLL; wr_ready SHALL be 1 only in IDLE.
REQ-019 Printable code (0x20..0x7E) SHALL be written at the cursor, then cur_col++; at cur_col=COLS-1 the write SHALL wrap to col 0 of the next row.
REQ-020 0x0A SHALL set cur_col to 0 and advance the row; 0x08 SHALL, if cur_col>0, decrement cur_col and write 0x20 there, else do nothing; 0x0C SHALL enter CLEAR; any other code SHALL be ignored.
REQ-021 Advancing the row from ROWS-1 SHALL keep cur_row=ROWS-1, increment top mod ROWS, and enter SCROLL.
REQ-022 SCROLL SHALL write 0x20 to all COLS cells of the new bottom physical row, 1 cell per cycle, then return to IDLE.
REQ-023 CLEAR SHALL write 0x20 to all COLS*ROWS cells, 1 per cycle, then set cursor (0,0) and top=0, and return to IDLE.
REQ-024 Display reads SHALL have priority-free access, using a dual-port RAM: write port for the FSM, read port for the display; a same-address read/write SHALL return the old data.

Reset
REQ-025 On reset, rgb=0, cur_col=0, cur_row=0, top=0, wr_ready=0, and the FSM SHALL enter CLEAR.
REQ-026 Reset asserted mid-CLEAR or mid-SCROLL SHALL restart CLEAR from cell 0, and any in-flight write SHALL be dropped.

Configuration
REQ-027 With CONSOLE_CURSOR_EN defined, a blink counter of parameter BLINK_CYCLES (default 25_000_000) SHALL toggle a phase bit; while the phase is 1, glyph rows 14..15 of the cursor cell SHALL be forced to FG.
REQ-028 Without CONSOLE_CURSOR_EN, the counter SHALL be absent and no cursor SHALL be drawn; all other behaviour SHALL be identical.

Structure
REQ-029 Package console_pkg SHALL hold the state enum, CELL_W=8, CELL_H=16, and the control-code constants (0x08, 0x0A, 0x0C, 0x20).
REQ-030 Sub-module console_ram SHALL implement the dual-port text buffer; the existing ascii_rom SHALL be instantiated for the glyphs.

Verification
REQ-031 Reset, then count cycles until wr_ready=1 -> equals COLS*ROWS (128 for defaults); the whole window renders BG.
REQ-032 Write 'A' (0x41) -> cur_col=1; pixel (X0+1,Y0+5) two cycles later -> rgb=FG per ROM row 5 of 'A'.
REQ-033 Write 33 printable chars with COLS=32 -> cur_row=1, cur_col=1, char 33 shown at logical row 1 col 0.
REQ-034 With cursor at row 3, send 0x0A -> top=1, wr_ready low for exactly 32 cycles; old row 1 now renders at logical row 0.
REQ-035 0x08 at col 0 -> no change; 0x0C mid-screen -> 128 clear cycles, cursor (0,0).
REQ-036 Assert reset during SCROLL -> full 128-cycle CLEAR, top=0; with CONSOLE_CURSOR_EN and BLINK_CYCLES=4 -> cursor rows 14..15 toggle every 4 cycles.
